// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer for the EX/MEM slot. Non-memory instructions are
//   written back combinationally in the same cycle. Loads and stores are
//   latched when accepted and issued to the data memory as one beat, or as
//   two beats when the access crosses an NB-byte lane boundary. Load data is
//   reassembled from the beats and then sign- or zero-extended.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, mem_en, mem_we      slot valid, load/store, store select
//   size, load_uns                access size (2^size bytes), zero-extend
//   addr_i, wdata_i               effective address, store data
//   rdsrc_i, pc4_i, pcimm_i,
//   imm_i, csr_i                  non-memory result select and sources
//   rd_i, regwrite_i              write-back tags
//   dm_req_valid/ready, dm_addr,
//   dm_we, dm_wstrb, dm_wdata     data memory request channel
//   dm_rvalid, dm_rdata           data memory response (one per request)
//   stall_o                       freeze IF..EX/MEM
//   wb_valid_o, result_o, rd_o,
//   regwrite_o                    write-back
//   fault_o                       one-cycle misalign / illegal-size pulse
//
// state | meaning
// IDLE  | waiting; non-memory ops pass straight through
// REQ0  | first beat request held until ready
// RSP0  | waiting for the first beat response
// REQ1  | second beat request (lane-crossing accesses only)
// RSP1  | waiting for the second beat response
// DONE  | one-cycle write-back of load data or latched result
// FAULT | one-cycle fault pulse, nothing written back
module mem_access_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [1:0]        size,
  input  logic              load_uns,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [2:0]        rdsrc_i,
  input  logic [XLEN-1:0]   pc4_i,
  input  logic [XLEN-1:0]   pcimm_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   csr_i,
  input  logic [4:0]        rd_i,
  input  logic              regwrite_i,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_we,
  output logic [XLEN/8-1:0] dm_wstrb,
  output logic [XLEN-1:0]   dm_wdata,
  input  logic              dm_rvalid,
  input  logic [XLEN-1:0]   dm_rdata,
  output logic              stall_o,
  output logic              wb_valid_o,
  output logic [XLEN-1:0]   result_o,
  output logic [4:0]        rd_o,
  output logic              regwrite_o,
  output logic              fault_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE, FAULT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   alt_q, alt_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d;
  logic [XLEN-1:0]   rdata1_q, rdata1_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic              cross_q, cross_d;
  logic [4:0]        rd_q, rd_d;
  logic              regwrite_q, regwrite_d;

  // Incoming instruction decode
  logic [XLEN-1:0]  addr_x;
  logic [XLEN-1:0]  sel_result;
  logic [OFF_W-1:0] in_off;
  logic [3:0]       in_bytes;
  logic             in_cross;
  logic             in_illegal;
  logic             accept;

  assign addr_x     = XLEN'(addr_i);
  assign in_off     = addr_i[OFF_W-1:0];
  assign in_bytes   = 4'd1 << size;
  assign in_cross   = (5'(in_off) + 5'(in_bytes)) > 5'(NB);
  assign in_illegal = (size == 2'd3) && (XLEN < 64);
  assign accept     = !rst && (state_q == IDLE) && in_valid && mem_en;

  always_comb begin
    case (rdsrc_i)
      3'd1:    sel_result = pc4_i;
      3'd2:    sel_result = pcimm_i;
      3'd3:    sel_result = imm_i;
      3'd4:    sel_result = csr_i;
      default: sel_result = addr_x;
    endcase
  end

  // Beat payloads from the latched access. Strobe and data are shifted into
  // a double-width window; the low half is beat 0, the high half beat 1.
  logic [OFF_W-1:0]  off_q;
  logic [3:0]        bytes_q;
  logic [ADDR_W-1:0] base_addr;
  logic [2*NB-1:0]   strb_wide;
  logic [2*XLEN-1:0] data_wide;
  logic [XLEN-1:0]   load_raw;
  logic [6:0]        ld_sh;
  logic [XLEN-1:0]   load_left;
  logic [XLEN-1:0]   load_ext;

  assign off_q     = addr_q[OFF_W-1:0];
  assign bytes_q   = 4'd1 << size_q;
  assign base_addr = addr_q & ~ADDR_W'(NB - 1);
  assign strb_wide = (2*NB)'((16'd1 << bytes_q) - 16'd1) << off_q;
  assign data_wide = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
  assign load_raw  = XLEN'({rdata1_q, rdata0_q} >> {off_q, 3'b000});
  // Extend from 8*bytes bits by parking the value at the top and shifting back.
  assign ld_sh     = 7'(XLEN) - {bytes_q, 3'b000};
  assign load_left = load_raw << ld_sh;
  assign load_ext  = uns_q ? (load_left >> ld_sh) : XLEN'($signed(load_left) >>> ld_sh);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    alt_d      = alt_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    cross_d    = cross_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d     = addr_i;
          wdata_d    = wdata_i;
          alt_d      = sel_result;
          size_d     = size;
          uns_d      = load_uns;
          we_d       = mem_we;
          cross_d    = in_cross;
          rd_d       = rd_i;
          regwrite_d = regwrite_i;
          rdata0_d   = '0;
          rdata1_d   = '0;
          if (in_illegal || (in_cross && (MISALIGN_SPLIT == 0))) state_d = FAULT;
          else                                                    state_d = REQ0;
        end
      end
      REQ0: if (dm_req_ready) state_d = RSP0;
      RSP0: begin
        if (dm_rvalid) begin
          rdata0_d = dm_rdata;
          state_d  = cross_q ? REQ1 : DONE;
        end
      end
      REQ1: if (dm_req_ready) state_d = RSP1;
      RSP1: begin
        if (dm_rvalid) begin
          rdata1_d = dm_rdata;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      alt_q      <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      cross_q    <= 1'b0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      alt_q      <= alt_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      we_q       <= we_d;
      cross_q    <= cross_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
    end
  end

  always_comb begin
    dm_req_valid = 1'b0;
    dm_addr      = '0;
    dm_we        = 1'b0;
    dm_wstrb     = '0;
    dm_wdata     = '0;
    stall_o      = 1'b0;
    wb_valid_o   = 1'b0;
    result_o     = '0;
    rd_o         = '0;
    regwrite_o   = 1'b0;
    fault_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && in_valid && !mem_en) begin
          wb_valid_o = 1'b1;
          result_o   = sel_result;
          rd_o       = rd_i;
          regwrite_o = regwrite_i;
        end
        stall_o = accept;
      end
      REQ0: begin
        dm_req_valid = 1'b1;
        dm_addr      = base_addr;
        dm_we        = we_q;
        if (we_q) begin
          dm_wstrb = strb_wide[NB-1:0];
          dm_wdata = data_wide[XLEN-1:0];
        end
        stall_o = 1'b1;
      end
      REQ1: begin
        dm_req_valid = 1'b1;
        dm_addr      = base_addr + ADDR_W'(NB);
        dm_we        = we_q;
        if (we_q) begin
          dm_wstrb = strb_wide[2*NB-1:NB];
          dm_wdata = data_wide[2*XLEN-1:XLEN];
        end
        stall_o = 1'b1;
      end
      RSP0, RSP1: stall_o = 1'b1;
      DONE: begin
        wb_valid_o = 1'b1;
        result_o   = we_q ? alt_q : load_ext;
        rd_o       = rd_q;
        regwrite_o = regwrite_q && !we_q;
      end
      FAULT:   fault_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, mem_en, mem_we, load_uns, regwrite_i;
  logic [1:0]  size;
  logic [31:0] addr_i, wdata_i, pc4_i, pcimm_i, imm_i, csr_i;
  logic [2:0]  rdsrc_i;
  logic [4:0]  rd_i;
  logic        dm_req_ready, dm_rvalid;
  logic [31:0] dm_rdata;

  logic        dm_req_valid, dm_we, stall_o, wb_valid_o, regwrite_o, fault_o;
  logic [31:0] dm_addr, dm_wdata, result_o;
  logic [3:0]  dm_wstrb;
  logic [4:0]  rd_o;

  logic        f_dm_req_valid, f_dm_we, f_stall, f_wb, f_regwrite, f_fault;
  logic [31:0] f_dm_addr, f_dm_wdata, f_result;
  logic [3:0]  f_dm_wstrb;
  logic [4:0]  f_rd;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_en(mem_en), .mem_we(mem_we),
    .size(size), .load_uns(load_uns), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdsrc_i(rdsrc_i), .pc4_i(pc4_i), .pcimm_i(pcimm_i), .imm_i(imm_i), .csr_i(csr_i),
    .rd_i(rd_i), .regwrite_i(regwrite_i),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_addr(dm_addr),
    .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .result_o(result_o), .rd_o(rd_o),
    .regwrite_o(regwrite_o), .fault_o(fault_o)
  );

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut_nosplit (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_en(mem_en), .mem_we(mem_we),
    .size(size), .load_uns(load_uns), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdsrc_i(rdsrc_i), .pc4_i(pc4_i), .pcimm_i(pcimm_i), .imm_i(imm_i), .csr_i(csr_i),
    .rd_i(rd_i), .regwrite_i(regwrite_i),
    .dm_req_valid(f_dm_req_valid), .dm_req_ready(dm_req_ready), .dm_addr(f_dm_addr),
    .dm_we(f_dm_we), .dm_wstrb(f_dm_wstrb), .dm_wdata(f_dm_wdata),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .stall_o(f_stall), .wb_valid_o(f_wb), .result_o(f_result), .rd_o(f_rd),
    .regwrite_o(f_regwrite), .fault_o(f_fault)
  );

  int total = 0;
  int bad   = 0;

  // Memory model: one response the cycle after each accepted request.
  bit          auto_rsp = 1'b1;
  logic [31:0] mem [0:255];
  int          n_beats;
  int          f_req_cnt;
  logic [31:0] beat_addr [4];
  logic [31:0] beat_data [4];
  logic [3:0]  beat_strb [4];
  logic        r_hs, r_we;
  logic [31:0] r_a, r_d;
  logic [3:0]  r_s;

  initial begin
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    n_beats   = 0;
    f_req_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      r_hs = dm_req_valid && dm_req_ready;
      r_a = dm_addr; r_d = dm_wdata; r_s = dm_wstrb; r_we = dm_we;
      if (f_dm_req_valid) f_req_cnt++;
      @(posedge clk);
      #1;
      if (r_hs) begin
        if (n_beats < 4) begin
          beat_addr[n_beats] = r_a; beat_data[n_beats] = r_d; beat_strb[n_beats] = r_s;
        end
        n_beats++;
      end
      if (auto_rsp) begin
        if (r_hs) begin
          dm_rvalid = 1'b1;
          dm_rdata  = r_we ? 32'h0 : mem[r_a[9:2]];
          if (r_we)
            for (int b = 0; b < 4; b++)
              if (r_s[b]) mem[r_a[9:2]][8*b +: 8] = r_d[8*b +: 8];
        end else begin
          dm_rvalid = 1'b0;
          dm_rdata  = '0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 0; mem_en = 0; mem_we = 0; size = 0; load_uns = 0;
    addr_i = 32'hFFFF_FFFF; wdata_i = 32'h5A5A_5A5A; rdsrc_i = 0;
    rd_i = 0; regwrite_i = 0;
  endtask

  // Presents a memory op for one cycle; returns stall_o seen in the accept cycle.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       output logic acc_stall);
    in_valid = 1; mem_en = 1; mem_we = we; size = sz; load_uns = uns;
    addr_i = a; wdata_i = wd; rd_i = rd; regwrite_i = 1; rdsrc_i = 0;
    @(negedge clk);
    acc_stall = stall_o;
    cyc();
    clear_in();
    mem_we = ~we; load_uns = ~uns;
  endtask

  // Waits for wb_valid_o or fault_o; n is the cycle index (accept = 0), -1 on timeout.
  task automatic wait_done(input int start, output int n);
    bit seen;
    seen = 0;
    n = start;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (wb_valid_o || fault_o) seen = 1;
      else begin
        cyc();
        n++;
      end
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset();
    rst = 1; clear_in();
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    total++; if (dm_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", dm_req_valid); end
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL reset_wb got=%b exp=0", wb_valid_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault_o); end
    total++; if (result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
    total++; if (dm_addr !== 32'h0 || dm_wstrb !== 4'h0) begin bad++; $display("FAIL reset_dm got=%h/%b exp=0/0", dm_addr, dm_wstrb); end
    cyc();
  endtask

  task automatic test_alu();
    in_valid = 1; mem_en = 0; addr_i = 32'h0000_1234; rdsrc_i = 0; rd_i = 5; regwrite_i = 1;
    pc4_i = 32'h0000_0104; pcimm_i = 32'hBEEF_0000; imm_i = 32'h0000_0777; csr_i = 32'h00C5_0000;
    @(negedge clk);
    total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL alu_wb got=%b exp=1", wb_valid_o); end
    total++; if (result_o !== 32'h0000_1234) begin bad++; $display("FAIL alu_result_addr got=%h exp=00001234", result_o); end
    total++; if (rd_o !== 5'd5 || regwrite_o !== 1'b1) begin bad++; $display("FAIL alu_tags got=%0d/%b exp=5/1", rd_o, regwrite_o); end
    total++; if (stall_o !== 1'b0 || dm_req_valid !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b/%b exp=0/0", stall_o, dm_req_valid); end
    cyc(); rdsrc_i = 2;
    @(negedge clk);
    total++; if (result_o !== 32'hBEEF_0000) begin bad++; $display("FAIL alu_result_pcimm got=%h exp=beef0000", result_o); end
    cyc(); rdsrc_i = 4;
    @(negedge clk);
    total++; if (result_o !== 32'h00C5_0000) begin bad++; $display("FAIL alu_result_csr got=%h exp=00c50000", result_o); end
    cyc(); clear_in();
    @(negedge clk);
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL alu_idle_wb got=%b exp=0", wb_valid_o); end
    cyc();
  endtask

  task automatic test_lw();
    logic st; int n;
    mem[32'h100 >> 2] = 32'h8765_4321; n_beats = 0;
    issue(0, 2'd2, 0, 32'h100, 32'h0, 5'd7, st);
    total++; if (st !== 1'b1) begin bad++; $display("FAIL lw_accept_stall got=%b exp=1", st); end
    // non-memory op presented while busy must be ignored
    in_valid = 1; mem_en = 0; rdsrc_i = 3; imm_i = 32'h0000_0777;
    @(negedge clk);
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL lw_busy_wb got=%b exp=0", wb_valid_o); end
    total++; if (dm_req_valid !== 1'b1 || dm_addr !== 32'h100) begin bad++; $display("FAIL lw_req got=%b/%h exp=1/100", dm_req_valid, dm_addr); end
    total++; if (dm_wstrb !== 4'b0000 || dm_we !== 1'b0) begin bad++; $display("FAIL lw_strb got=%b/%b exp=0000/0", dm_wstrb, dm_we); end
    cyc(); clear_in();
    wait_done(2, n);
    total++; if (n !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", n); end
    total++; if (result_o !== 32'h8765_4321) begin bad++; $display("FAIL lw_result got=%h exp=87654321", result_o); end
    total++; if (rd_o !== 5'd7 || regwrite_o !== 1'b1) begin bad++; $display("FAIL lw_tags got=%0d/%b exp=7/1", rd_o, regwrite_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lw_done_stall got=%b exp=0", stall_o); end
    cyc();
    @(negedge clk);
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL lw_after_wb got=%b exp=0", wb_valid_o); end
    total++; if (n_beats !== 1) begin bad++; $display("FAIL lw_beats got=%0d exp=1", n_beats); end
    cyc();
  endtask

  task automatic test_lh_split();
    logic st; int n;
    mem[32'h100 >> 2] = 32'hAABB_CCDD; mem[32'h104 >> 2] = 32'h1122_3344;
    mem[32'h108 >> 2] = 32'h0000_0099; n_beats = 0;
    issue(0, 2'd1, 0, 32'h103, 32'h0, 5'd3, st);
    wait_done(1, n);
    total++; if (n !== 5) begin bad++; $display("FAIL lh_latency got=%0d exp=5", n); end
    total++; if (result_o !== 32'h0000_44AA) begin bad++; $display("FAIL lh_result got=%h exp=000044aa", result_o); end
    cyc();
    total++; if (n_beats !== 2 || beat_addr[0] !== 32'h100 || beat_addr[1] !== 32'h104) begin
      bad++; $display("FAIL lh_beats got=%0d %h %h exp=2 100 104", n_beats, beat_addr[0], beat_addr[1]); end
    issue(0, 2'd1, 0, 32'h107, 32'h0, 5'd3, st);
    wait_done(1, n);
    total++; if (result_o !== 32'hFFFF_9911) begin bad++; $display("FAIL lh_sign_result got=%h exp=ffff9911", result_o); end
    cyc();
    issue(0, 2'd2, 0, 32'h101, 32'h0, 5'd3, st);
    wait_done(1, n);
    total++; if (result_o !== 32'h44AA_BBCC || n !== 5) begin bad++; $display("FAIL lw_mis_result got=%h/%0d exp=44aabbcc/5", result_o, n); end
    cyc();
  endtask

  task automatic test_sw_split();
    logic st; int n;
    n_beats = 0;
    issue(1, 2'd2, 0, 32'h102, 32'hDEAD_BEEF, 5'd9, st);
    wait_done(1, n);
    total++; if (n !== 5) begin bad++; $display("FAIL sw_latency got=%0d exp=5", n); end
    total++; if (wb_valid_o !== 1'b1 || regwrite_o !== 1'b0) begin bad++; $display("FAIL sw_wb got=%b/%b exp=1/0", wb_valid_o, regwrite_o); end
    total++; if (result_o !== 32'h0000_0102) begin bad++; $display("FAIL sw_result got=%h exp=00000102", result_o); end
    cyc();
    total++; if (n_beats !== 2) begin bad++; $display("FAIL sw_beats got=%0d exp=2", n_beats); end
    total++; if (beat_addr[0] !== 32'h100 || beat_strb[0] !== 4'b1100 || beat_data[0] !== 32'hBEEF_0000) begin
      bad++; $display("FAIL sw_beat0 got=%h %b %h exp=100 1100 beef0000", beat_addr[0], beat_strb[0], beat_data[0]); end
    total++; if (beat_addr[1] !== 32'h104 || beat_strb[1] !== 4'b0011 || beat_data[1] !== 32'h0000_DEAD) begin
      bad++; $display("FAIL sw_beat1 got=%h %b %h exp=104 0011 0000dead", beat_addr[1], beat_strb[1], beat_data[1]); end
  endtask

  task automatic test_sb_inlane();
    logic st; int n;
    n_beats = 0;
    issue(1, 2'd0, 0, 32'h101, 32'h1234_5678, 5'd4, st);
    wait_done(1, n);
    total++; if (n !== 3) begin bad++; $display("FAIL sb_latency got=%0d exp=3", n); end
    cyc();
    total++; if (n_beats !== 1 || beat_addr[0] !== 32'h100 || beat_strb[0] !== 4'b0010 || beat_data[0] !== 32'h3456_7800) begin
      bad++; $display("FAIL sb_beat got=%0d %h %b %h exp=1 100 0010 34567800", n_beats, beat_addr[0], beat_strb[0], beat_data[0]); end
  endtask

  task automatic test_illegal_size();
    logic st; int n;
    n_beats = 0;
    issue(0, 2'd3, 0, 32'h100, 32'h0, 5'd2, st);
    wait_done(1, n);
    total++; if (n !== 1 || fault_o !== 1'b1) begin bad++; $display("FAIL ld_fault got=%0d/%b exp=1/1", n, fault_o); end
    total++; if (wb_valid_o !== 1'b0 || regwrite_o !== 1'b0 || dm_req_valid !== 1'b0) begin
      bad++; $display("FAIL ld_fault_out got=%b%b%b exp=000", wb_valid_o, regwrite_o, dm_req_valid); end
    cyc();
    @(negedge clk);
    total++; if (fault_o !== 1'b0 || stall_o !== 1'b0 || n_beats !== 0) begin
      bad++; $display("FAIL ld_fault_after got=%b/%b/%0d exp=0/0/0", fault_o, stall_o, n_beats); end
    cyc();
  endtask

  task automatic test_fault_nosplit();
    int n;
    mem[32'h100 >> 2] = 32'hAABB_CCDD; mem[32'h104 >> 2] = 32'h1122_3344;
    f_req_cnt = 0;
    in_valid = 1; mem_en = 1; mem_we = 0; size = 2'd2; load_uns = 0;
    addr_i = 32'h101; rd_i = 6; regwrite_i = 1; rdsrc_i = 0;
    @(negedge clk);
    total++; if (f_stall !== 1'b1) begin bad++; $display("FAIL ns_accept_stall got=%b exp=1", f_stall); end
    cyc(); clear_in();
    @(negedge clk);
    total++; if (f_fault !== 1'b1 || f_wb !== 1'b0 || f_regwrite !== 1'b0) begin
      bad++; $display("FAIL ns_fault got=%b%b%b exp=100", f_fault, f_wb, f_regwrite); end
    total++; if (f_stall !== 1'b0 || f_dm_req_valid !== 1'b0) begin bad++; $display("FAIL ns_fault_stall got=%b/%b exp=0/0", f_stall, f_dm_req_valid); end
    cyc();
    @(negedge clk);
    total++; if (f_fault !== 1'b0 || f_stall !== 1'b0) begin bad++; $display("FAIL ns_after got=%b/%b exp=0/0", f_fault, f_stall); end
    cyc();
    wait_done(3, n);
    total++; if (result_o !== 32'h44AA_BBCC || f_req_cnt !== 0) begin
      bad++; $display("FAIL ns_split_ref got=%h/%0d exp=44aabbcc/0", result_o, f_req_cnt); end
    cyc();
  endtask

  task automatic test_lb_wait();
    logic st; int n;
    mem[0] = 32'h0000_0080; dm_req_ready = 0;
    issue(0, 2'd0, 0, 32'h0, 32'h0, 5'd8, st);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (stall_o !== 1'b1 || dm_req_valid !== 1'b1) begin
        bad++; $display("FAIL lb_wait_hold[%0d] got=%b/%b exp=1/1", k, stall_o, dm_req_valid); end
      total++; if (dm_addr !== 32'h0 || dm_we !== 1'b0 || dm_wstrb !== 4'h0) begin
        bad++; $display("FAIL lb_wait_payload[%0d] got=%h/%b/%b exp=0/0/0000", k, dm_addr, dm_we, dm_wstrb); end
      cyc();
    end
    dm_req_ready = 1;
    wait_done(5, n);
    total++; if (n !== 7) begin bad++; $display("FAIL lb_latency got=%0d exp=7", n); end
    total++; if (result_o !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_result got=%h exp=ffffff80", result_o); end
    cyc();
    issue(0, 2'd0, 1, 32'h0, 32'h0, 5'd8, st);
    wait_done(1, n);
    total++; if (result_o !== 32'h0000_0080 || n !== 3) begin bad++; $display("FAIL lbu_result got=%h/%0d exp=00000080/3", result_o, n); end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic st; int n;
    auto_rsp = 0; dm_rvalid = 0; dm_rdata = 0; dm_req_ready = 1;
    issue(0, 2'd2, 0, 32'h100, 32'h0, 5'd7, st);
    cyc();
    @(negedge clk);
    total++; if (stall_o !== 1'b1 || dm_req_valid !== 1'b0) begin bad++; $display("FAIL rm_rsp0 got=%b/%b exp=1/0", stall_o, dm_req_valid); end
    cyc(); rst = 1;
    cyc(); rst = 0; dm_rvalid = 1; dm_rdata = 32'h0000_0055;
    @(negedge clk);
    total++; if (wb_valid_o !== 1'b0 || stall_o !== 1'b0 || dm_req_valid !== 1'b0) begin
      bad++; $display("FAIL rm_after got=%b%b%b exp=000", wb_valid_o, stall_o, dm_req_valid); end
    total++; if (result_o !== 32'h0 || regwrite_o !== 1'b0) begin bad++; $display("FAIL rm_result got=%h/%b exp=0/0", result_o, regwrite_o); end
    cyc(); dm_rvalid = 0; dm_rdata = 0;
    @(negedge clk);
    total++; if (wb_valid_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL rm_idle got=%b/%b exp=0/0", wb_valid_o, stall_o); end
    auto_rsp = 1;
    cyc();
    mem[32'h100 >> 2] = 32'h1357_9BDF;
    issue(0, 2'd2, 0, 32'h100, 32'h0, 5'd7, st);
    wait_done(1, n);
    total++; if (result_o !== 32'h1357_9BDF || n !== 3) begin bad++; $display("FAIL rm_new_lw got=%h/%0d exp=13579bdf/3", result_o, n); end
    cyc();
  endtask

  initial begin
    rst = 1; dm_req_ready = 1;
    pc4_i = 0; pcimm_i = 0; imm_i = 0; csr_i = 0;
    clear_in();
    test_reset();
    test_alu();
    test_lw();
    test_lh_split();
    test_sw_split();
    test_sb_inlane();
    test_illegal_size();
    test_fault_nosplit();
    test_lb_wait();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
